decifra_xor: RTL and testbench

Bit-serial XOR decipher, the receive-side counterpart of `cifra_xor`. It captures one ciphertext word and key on a `start` request and recovers the plaintext LSB-first, one bit per cycle, through a four-state FSM. It then presents the result with a level `done` that is held until the requester drops `start`. It sits after `cifra_xor` in the link datapath and uses the same start/done handshake, so one controller can drive both blocks.

---
 rtl/decifra_xor.sv | 102 ++++++++++
 tb/tb_decifra_xor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decifra_xor.sv
// Bit-serial XOR decipher: captures ciphertext/key on start, recovers plaintext LSB-first.
// Optional even-parity check on the ciphertext is built when DECIFRA_XOR_PARITY_EN is defined.
module decifra_xor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] ciphertext,
  input  logic [WIDTH-1:0] key,
`ifdef DECIFRA_XOR_PARITY_EN
  input  logic             ct_parity,
  output logic             parity_err,
`endif
  output logic [WIDTH-1:0] plaintext,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_LOAD  = 2'b01;
  localparam logic [1:0] S_SHIFT = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [1:0]       current_state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] ct_sr;
  logic [WIDTH-1:0] key_sr;
  logic [WIDTH-1:0] pt_sr;
  logic [WIDTH-1:0] pt_next;
  logic [CW-1:0]    cnt;

  // The recovered bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  assign pt_next = {ct_sr[0] ^ key_sr[0], pt_sr[WIDTH-1:1]};

  logic unused_pt_lsb;
  assign unused_pt_lsb = pt_sr[0];

  always_comb begin
    next_state = current_state;
    case (current_state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = S_SHIFT;
      S_SHIFT: if (cnt == LAST) next_state = S_DONE;
      S_DONE:  if (!start) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign busy = (current_state == S_LOAD) || (current_state == S_SHIFT);

`ifdef DECIFRA_XOR_PARITY_EN
  logic par_cap;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      current_state <= S_IDLE;
      done          <= 1'b0;
      plaintext     <= '0;
      ct_sr         <= '0;
      key_sr        <= '0;
      pt_sr         <= '0;
      cnt           <= '0;
`ifdef DECIFRA_XOR_PARITY_EN
      par_cap       <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      current_state <= next_state;
      done          <= (next_state == S_DONE);
      case (current_state)
        S_LOAD: begin
          ct_sr   <= ciphertext;
          key_sr  <= key;
          pt_sr   <= '0;
          cnt     <= '0;
`ifdef DECIFRA_XOR_PARITY_EN
          par_cap <= ^{ciphertext, ct_parity};
`endif
        end
        S_SHIFT: begin
          pt_sr  <= pt_next;
          ct_sr  <= ct_sr >> 1;
          key_sr <= key_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            plaintext  <= pt_next;
`ifdef DECIFRA_XOR_PARITY_EN
            parity_err <= par_cap;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decifra_xor.sv
// Directed bench for decifra_xor (WIDTH=8): handshake timing, vectors, reset and hold behaviour.
module tb_decifra_xor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] ciphertext;
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] plaintext;
  logic             done;
  logic             busy;
`ifdef DECIFRA_XOR_PARITY_EN
  logic             ct_parity;
  logic             parity_err;
`endif

  int checks = 0;
  int errors = 0;

  decifra_xor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
`ifdef DECIFRA_XOR_PARITY_EN
    .ct_parity  (ct_parity),
    .parity_err (parity_err),
`endif
    .plaintext  (plaintext),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full handshake: start, walk the state sequence, check result, drop start.
  task automatic run_op(input string tag, input logic [7:0] ct, input logic [7:0] k,
                        input logic [7:0] exp);
    ciphertext = ct;
    key        = k;
    start      = 1'b1;
    @(negedge clk);
    chk({tag, "_st_load"}, 32'(dut.current_state), 32'h1);
    @(negedge clk);
    chk({tag, "_st_shift"}, 32'(dut.current_state), 32'h2);
    repeat (7) @(negedge clk);
    chk({tag, "_st_shift_end"}, 32'(dut.current_state), 32'h2);
    @(negedge clk);
    chk({tag, "_st_done"}, 32'(dut.current_state), 32'h3);
    chk({tag, "_done"}, 32'(done), 32'h1);
    chk({tag, "_pt"}, 32'(plaintext), 32'(exp));
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_st_idle"}, 32'(dut.current_state), 32'h0);
    chk({tag, "_done_fall"}, 32'(done), 32'h0);
  endtask

  initial begin
    int first_done;
    int busy_cnt;
    int load_cnt;
    int done_cnt;

    reset      = 1'b1;
    start      = 1'b0;
    ciphertext = '0;
    key        = '0;
`ifdef DECIFRA_XOR_PARITY_EN
    ct_parity  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(dut.current_state), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pt", 32'(plaintext), 32'h0);
`ifdef DECIFRA_XOR_PARITY_EN
    chk("rst_perr", 32'(parity_err), 32'h0);
`endif

    // First vector: latency and busy window.
    reset      = 1'b0;
    ciphertext = 8'b1111_1111;
    key        = 8'b1011_0111;
    start      = 1'b1;
    first_done = 0;
    busy_cnt   = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (done && first_done == 0) first_done = i;
      if (busy) busy_cnt++;
    end
    chk("lat_done_edge", 32'(first_done), 32'd10);
    chk("lat_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("v0_pt", 32'(plaintext), 32'h48);
    chk("v0_done_held", 32'(done), 32'h1);
    start = 1'b0;
    @(negedge clk);
    chk("v0_done_fall", 32'(done), 32'h0);

    run_op("v1", 8'b0100_1000, 8'b1011_0111, 8'b1111_1111);
    run_op("v2", 8'b0000_0000, 8'b1111_1111, 8'b1111_1111);
    run_op("v3", 8'b1111_1111, 8'b1111_1111, 8'b0000_0000);

    // Input change after LOAD and start dropped mid-SHIFT.
    ciphertext = 8'h3C;
    key        = 8'h0F;
    start      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ciphertext = 8'b1010_1010;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("drop_done", 32'(done), 32'h1);
    chk("drop_pt", 32'(plaintext), 32'h33);
    @(negedge clk);
    chk("drop_done_pulse", 32'(done), 32'h0);
    chk("drop_state", 32'(dut.current_state), 32'h0);

    // Reset on the 4th SHIFT step.
    ciphertext = 8'h12;
    key        = 8'h34;
    start      = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", 32'(dut.current_state), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_pt", 32'(plaintext), 32'h0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    run_op("after_rst", 8'h12, 8'h34, 8'h26);

    // start held for 30 cycles: exactly one operation.
    ciphertext = 8'h5A;
    key        = 8'hFF;
    start      = 1'b1;
    load_cnt   = 0;
    done_cnt   = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dut.current_state == 2'b01) load_cnt++;
      if (done) done_cnt++;
    end
    chk("hold_loads", 32'(load_cnt), 32'd1);
    chk("hold_done_cycles", 32'(done_cnt), 32'd21);
    chk("hold_pt", 32'(plaintext), 32'hA5);
    start = 1'b0;
    @(negedge clk);
    chk("hold_done_fall", 32'(done), 32'h0);

`ifdef DECIFRA_XOR_PARITY_EN
    ct_parity = 1'b0;
    run_op("par0", 8'hFF, 8'hB7, 8'h48);
    chk("par0_err", 32'(parity_err), 32'h0);
    ct_parity = 1'b1;
    run_op("par1", 8'hFF, 8'h0F, 8'hF0);
    chk("par1_err", 32'(parity_err), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
